// File: rtl/pc8001m_kbd_pkg.sv
// pc8001m_kbd_pkg: scancode prefixes, frame length and TX state type shared by
// the PS/2 key serializer and its byte FIFO.
package pc8001m_kbd_pkg;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam int         FRAME_LEN = 11;
    typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} tx_state_t;
endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: synchronous 8-bit FIFO with an occupancy count; the caller
// guarantees no push when full and no pop when empty.
module ps2_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ps2_key_serializer.sv
// ps2_key_serializer: turns MiSTer ps2_key toggle events into make/break
// scancode bytes and shifts them out as device-side 11-bit PS/2 frames.
module ps2_key_serializer
    import pc8001m_kbd_pkg::*;
#(
    parameter int CLK_DIV    = 1145,
    parameter int IDLE_GAP   = 2290,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        enable,
    output logic        ps2_clk,
    output logic        ps2_data,
    output logic        busy,
    output logic        overflow
);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CMAX = CLK_DIV > IDLE_GAP ? CLK_DIV : IDLE_GAP;
    localparam int TW   = $clog2(CMAX + 1);

    logic                 primed, last_tog;
    logic [2:0]           pend;
    logic [7:0]           code, push_byte, fifo_out;
    logic                 push, pop, event_seen, fits;
    logic [1:0]           need;
    logic [CW-1:0]        count;
    tx_state_t            state, state_n;
    logic [TW-1:0]        cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic [FRAME_LEN-1:0] sh, sh_n;
    logic                 clk_n, data_n, busy_n;

    ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .push(push),
        .din(push_byte),
        .pop(pop),
        .dout(fifo_out),
        .count(count)
    );

    // pend flags {E0 pending, F0 pending, scancode pending}, drained one per cycle
    assign push       = |pend;
    assign push_byte  = pend[2] ? PS2_EXT : pend[1] ? PS2_BREAK : code;
    assign event_seen = primed && !push && (ps2_key[10] != last_tog);
    assign need       = 2'd1 + {1'b0, ps2_key[8]} + {1'b0, !ps2_key[9]};
    assign fits       = CW'(FIFO_DEPTH) - count >= CW'(need);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed   <= 1'b0;
            last_tog <= 1'b0;
            pend     <= '0;
            code     <= '0;
            overflow <= 1'b0;
        end else if (!primed) begin
            primed   <= 1'b1;
            last_tog <= ps2_key[10];
        end else if (event_seen) begin
            last_tog <= ps2_key[10];
            if (fits) begin
                pend <= {ps2_key[8], !ps2_key[9], 1'b1};
                code <= ps2_key[7:0];
            end else begin
                overflow <= 1'b1;
            end
        end else if (push) begin
            pend <= pend[2] ? {1'b0, pend[1:0]} : pend[1] ? 3'b001 : 3'b000;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + TW'(1);
        idx_n   = idx;
        sh_n    = sh;
        clk_n   = ps2_clk;
        data_n  = ps2_data;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable && count != '0) begin
                    pop     = 1'b1;
                    sh_n    = {1'b1, ~^fifo_out, fifo_out, 1'b0};
                    state_n = BIT_HI;
                    idx_n   = '0;
                    data_n  = 1'b0;
                end
            end
            BIT_HI: if (cnt == TW'(CLK_DIV - 1)) begin
                state_n = BIT_LO;
                cnt_n   = '0;
                clk_n   = 1'b0;
            end
            BIT_LO: if (cnt == TW'(CLK_DIV - 1)) begin
                cnt_n = '0;
                clk_n = 1'b1;
                if (idx == 4'(FRAME_LEN - 1)) begin
                    state_n = GAP;
                    data_n  = 1'b1;
                end else begin
                    state_n = BIT_HI;
                    idx_n   = idx + 4'd1;
                    data_n  = sh[idx_n];
                end
            end
            GAP: if (cnt == TW'(IDLE_GAP - 1)) begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE || count + CW'(push) - CW'(pop) != '0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '1;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            sh       <= sh_n;
            ps2_clk  <= clk_n;
            ps2_data <= data_n;
            busy     <= busy_n;
        end
    end
endmodule

// File: tb/tb_ps2_key_serializer.sv
// tb_ps2_key_serializer: random and directed key events; a line-level PS/2
// receiver decodes frames and compares them against a byte scoreboard.
module tb_ps2_key_serializer;
    localparam int CLK_DIV  = 4;
    localparam int IDLE_GAP = 8;
    localparam int DEPTH    = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b1;
    logic [10:0] ps2_key = 11'h400;
    logic        ps2_clk, ps2_data, busy, overflow;

    ps2_key_serializer #(.CLK_DIV(CLK_DIV), .IDLE_GAP(IDLE_GAP), .FIFO_DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ps2_key(ps2_key),
        .enable(enable),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int          checks = 0, passed = 0;
    logic [7:0]  exp_q[$];
    logic        tog = 1'b1, model_ovf = 1'b0;
    int          frames = 0, cyc = 0, nbits = 0, lo_cnt = 0, hi_cnt = 0, end_cyc = 0;
    logic        in_frame = 1'b0, have_end = 1'b0, gap_en = 1'b0;
    logic        prev_clk = 1'b1, prev_data = 1'b1;
    logic [10:0] frame = '0, last_frame = '0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Reference model: an event expands to [E0] [F0] code, or is dropped whole
    // when the outstanding bytes plus this event would exceed the FIFO depth.
    task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
        int need = 1 + int'(ext) + int'(!pressed);
        tog = ~tog;
        ps2_key = {tog, pressed, ext, code};
        if (exp_q.size() + need > DEPTH) model_ovf = 1'b1;
        else begin
            if (ext) exp_q.push_back(8'hE0);
            if (!pressed) exp_q.push_back(8'hF0);
            exp_q.push_back(code);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain_within_budget", int'(n < budget), 1);
    endtask

    // Line-level receiver: samples on the falling system-clock edge.
    always @(negedge clk_sys) begin
        cyc++;
        if (!reset_n) begin
            in_frame = 1'b0;
            have_end = 1'b0;
            nbits = 0;
            lo_cnt = 0;
            prev_clk = 1'b1;
            prev_data = 1'b1;
        end else begin
            gap_en = gap_en & enable;
            if (ps2_data != prev_data) chk("data_moves_with_clk_high", ps2_clk, 1);
            if (!in_frame && prev_data && !ps2_data && ps2_clk) begin
                in_frame = 1'b1;
                nbits = 0;
                hi_cnt = 0;
                if (have_end && gap_en) chk("inter_frame_gap", cyc - end_cyc, IDLE_GAP + 1);
                have_end = 1'b0;
            end
            if (!prev_clk && ps2_clk) begin
                chk("clk_low_width", lo_cnt, CLK_DIV);
                lo_cnt = 0;
                hi_cnt = 0;
                if (nbits == 11) begin
                    in_frame = 1'b0;
                    end_cyc = cyc;
                    have_end = exp_q.size() > 0;
                    gap_en = 1'b1;
                end
            end
            if (!ps2_clk) lo_cnt++;
            else if (in_frame) hi_cnt++;
            if (prev_clk && !ps2_clk && nbits < 11) begin
                chk("clk_high_width", hi_cnt, CLK_DIV);
                frame[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    frames++;
                    last_frame = frame;
                    chk("start_bit", frame[0], 0);
                    chk("stop_bit", frame[10], 1);
                    chk("odd_parity", $countones(frame[9:1]) % 2, 1);
                    chk("frame_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("frame_byte", frame[8:1], exp_q.pop_front());
                end
            end
            prev_clk = ps2_clk;
            prev_data = ps2_data;
        end
    end

    initial begin
        int n, f;
        tick(2);
        chk("reset_ps2_clk", ps2_clk, 1);
        chk("reset_ps2_data", ps2_data, 1);
        chk("reset_busy", busy, 0);
        chk("reset_overflow", overflow, 0);
        reset_n = 1'b1;
        tick(100);
        chk("prime_busy", busy, 0);
        chk("prime_frames", frames, 0);

        f = frames;
        send(1'b1, 1'b0, 8'h1C);
        wait_idle(500);
        chk("make_frames", frames, f + 1);
        chk("make_bits", last_frame, 11'h438);

        f = frames;
        send(1'b0, 1'b1, 8'h75);
        wait_idle(1000);
        chk("ext_break_frames", frames, f + 3);
        chk("ext_break_last_bits", last_frame, 11'h4EA);

        enable = 1'b0;
        f = frames;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b1, 8'($urandom));
            tick(4);
        end
        tick(10);
        chk("overflow_flag", overflow, model_ovf);
        chk("overflow_busy_held", busy, 1);
        chk("overflow_no_frames", frames, f);
        enable = 1'b1;
        wait_idle(3000);
        chk("overflow_drained_frames", frames, f + 6);

        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (exp_q.size() > DEPTH - 3 && n < 2000) begin
                tick(1);
                n++;
            end
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            tick($urandom_range(4, 40));
        end
        wait_idle(6000);
        chk("random_overflow_sticky", overflow, model_ovf);

        f = frames;
        send(1'b1, 1'b0, 8'($urandom));
        tick(2);
        send(1'b1, 1'b0, 8'($urandom));
        wait_idle(1000);
        chk("back_to_back_frames", frames, f + 2);

        f = frames;
        send(1'b1, 1'b0, 8'h5A);
        tick(4);
        send(1'b1, 1'b0, 8'h00);
        n = 0;
        while (!(in_frame && nbits >= 5) && n < 500) begin
            tick(1);
            n++;
        end
        chk("reach_bit5", int'(n < 500), 1);
        enable = 1'b0;
        n = 0;
        while (frames < f + 1 && n < 500) begin
            tick(1);
            n++;
        end
        tick(100);
        chk("enable_low_frames", frames, f + 1);
        chk("enable_low_queue", exp_q.size(), 1);
        chk("enable_low_busy", busy, 1);
        enable = 1'b1;
        n = 0;
        while (!(in_frame && nbits >= 3 && !ps2_clk) && n < 500) begin
            tick(1);
            n++;
        end
        chk("reach_held_frame", int'(n < 500), 1);
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_clk", ps2_clk, 1);
        chk("async_reset_data", ps2_data, 1);
        exp_q.delete();
        model_ovf = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(200);
        chk("post_reset_frames", frames, f + 1);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_overflow", overflow, model_ovf);

        f = frames;
        send(1'b1, 1'b0, 8'h1C);
        wait_idle(500);
        chk("post_reset_make", last_frame, 11'h438);
        chk("post_reset_make_frames", frames, f + 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
